// File: rtl/mc_fifo_pkg.sv
// Shared definitions for the memory-controller FIFO family.
// Holds the read-mode constants and the helper that sizes level/threshold buses.
package mc_fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Level and threshold buses must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// Single-clock simple dual-port RAM with a registered read port.
// Ports: clk, rst_n (clears only the read register),
//        we_i/waddr_i/wdata_i write port,
//        re_i/raddr_i read request, rdata_o registered read data (holds when re_i=0).
module sync_dp_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read.
// Ports: clk, rst_n (async, active-low), flush (sync clear of contents and errors),
//        wr_en/wr_data write side, rd_en pop request, rd_data/rd_vld read side,
//        full/empty, afull/aempty with runtime thresholds afull_thr/aempty_thr,
//        level (words stored incl. FWFT output stage), sticky overflow/underflow.
module sync_fifo_fwft
  import mc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FWFT       = FIFO_MODE_STD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_vld,
  output logic                        full,
  output logic                        empty,
  input  logic [$clog2(FIFO_DEPTH):0] afull_thr,
  input  logic [$clog2(FIFO_DEPTH):0] aempty_thr,
  output logic                        afull,
  output logic                        aempty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_WIDTH  = level_width(FIFO_DEPTH);
  localparam bit          IS_FWFT    = (FWFT == FIFO_MODE_FWFT);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_WIDTH-1:0]  level_q, level_d;
  logic                  vld_q, vld_d;
  logic                  sel_byp_q, sel_byp_d;
  logic [DATA_WIDTH-1:0] byp_q, byp_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  ram_we, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_acc, rd_acc, ram_empty, need_load;

  // Flags decode from the registered level.
  assign full   = (level_q == LVL_WIDTH'(FIFO_DEPTH));
  assign empty  = IS_FWFT ? ~vld_q : (level_q == '0);
  assign afull  = (afull_thr != '0) && (level_q >= afull_thr);
  assign aempty = (level_q <= aempty_thr);

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // FWFT: words in RAM = level minus the occupied output stage.
  assign ram_empty = (level_q == LVL_WIDTH'(vld_q));
  assign need_load = ~vld_q | rd_acc;

  assign rd_data   = (IS_FWFT && sel_byp_q) ? byp_q : ram_rdata;
  assign rd_vld    = vld_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  sync_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state: pointers, level, output stage and error flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    vld_d     = vld_q;
    sel_byp_d = sel_byp_q;
    byp_d     = byp_q;
    ovf_d     = ovf_q | (wr_en & full);
    unf_d     = unf_q | (rd_en & empty);
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      vld_d    = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      level_d = level_q + LVL_WIDTH'(wr_acc) - LVL_WIDTH'(rd_acc);
      ram_we  = wr_acc;
      if (!IS_FWFT) begin
        ram_re = rd_acc;
        vld_d  = rd_acc;
      end else if (need_load) begin
        // Refill the output stage: oldest RAM word first, else bypass the write.
        if (!ram_empty) begin
          ram_re    = 1'b1;
          vld_d     = 1'b1;
          sel_byp_d = 1'b0;
        end else if (wr_acc) begin
          ram_we    = 1'b0;
          byp_d     = wr_data;
          sel_byp_d = 1'b1;
          vld_d     = 1'b1;
        end else begin
          vld_d     = 1'b0;
        end
      end
      if (ram_we) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (ram_re) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      vld_q     <= 1'b0;
      sel_byp_q <= 1'b0;
      byp_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      vld_q     <= vld_d;
      sel_byp_q <= sel_byp_d;
      byp_q     <= byp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

endmodule
